// File: rtl/spi_mem_pkg.sv
// Shared constants for the SPI memory controller: opcodes, FSM encoding,
// RAM/flash target type and the default RAM select bit.
package spi_mem_pkg;

  localparam int unsigned RAM_BASE_BIT_DEF = 15;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CMD  = 3'd1;
  localparam logic [2:0] ST_ADDR = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic {
    TGT_FLASH = 1'b0,
    TGT_RAM   = 1'b1
  } target_e;

  function automatic logic [7:0] opcode_for(input logic is_read);
    return is_read ? OP_READ : OP_WRITE;
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// Mode-0 byte serializer/deserializer. A new byte may be loaded on the same
// edge that ends the previous one, so consecutive bytes stream without gaps.
module spi_shift_engine (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] data_i,
  input  logic       miso_i,
  output logic       ready_o,
  output logic       done_o,
  output logic [7:0] rx_o,
  output logic       sclk_o,
  output logic       mosi_o
);

  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [2:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       sclk_q, sclk_d;
  logic       done_q, done_d;
  logic       sample_s;
  logic       byte_end_s;

  // The edge that ends a high phase samples MISO and advances the bit.
  assign sample_s   = busy_q & sclk_q;
  assign byte_end_s = sample_s & (cnt_q == 3'd7);
  assign ready_o    = ~busy_q | byte_end_s;

  // Next-state logic for the shifter and spi_clk phase.
  always_comb begin
    tx_d   = tx_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    sclk_d = sclk_q;
    rx_d   = sample_s ? {rx_q[6:0], miso_i} : rx_q;
    done_d = byte_end_s;
    if (start_i && ready_o) begin
      tx_d   = data_i;
      cnt_d  = 3'd0;
      busy_d = 1'b1;
      sclk_d = 1'b0;
    end else if (sample_s) begin
      tx_d   = {tx_q[6:0], 1'b0};
      cnt_d  = cnt_q + 3'd1;
      sclk_d = 1'b0;
      busy_d = ~byte_end_s;
    end else if (busy_q) begin
      sclk_d = 1'b1;
    end else begin
      sclk_d = 1'b0;
    end
  end

  // Engine state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q   <= 8'h00;
      rx_q   <= 8'h00;
      cnt_q  <= 3'd0;
      busy_q <= 1'b0;
      sclk_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      tx_q   <= tx_d;
      rx_q   <= rx_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      sclk_q <= sclk_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;
  assign rx_o   = rx_q;
  assign sclk_o = sclk_q;
  assign mosi_o = tx_q[7];

endmodule

// File: rtl/spi_mem_ctrl.sv
// CPU-bus to SPI flash/RAM bridge: opcode, address and one data byte per
// access, with the CPU stalled until the transfer completes.
module spi_mem_ctrl
  import spi_mem_pkg::*;
#(
  parameter int ADDR_BYTES   = 3,
  parameter int RAM_BASE_BIT = RAM_BASE_BIT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bus_address_in,
  input  logic [7:0]  bus_data_in,
  input  logic        bus_read,
  input  logic        bus_write,
  output logic [7:0]  bus_data_out,
  output logic        bus_wait,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        flash_ce_n,
  output logic        ram_ce_n
);

  localparam int TOTAL_BITS = 16 + 8 * ADDR_BYTES;
  localparam int CNT_W      = $clog2(TOTAL_BITS + 1);
  localparam int ADDR_W     = 8 * ADDR_BYTES;
  localparam logic [CNT_W-1:0] CMD_END  = CNT_W'(8);
  localparam logic [CNT_W-1:0] ADDR_END = CNT_W'(8 + ADDR_W);
  localparam logic [CNT_W-1:0] BITS_ALL = CNT_W'(TOTAL_BITS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] bits_q, bits_d;
  logic [14:0]      addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             is_read_q, is_read_d;
  logic             flash_ce_q, flash_ce_d;
  logic             ram_ce_q, ram_ce_d;

  logic              req_s;
  logic              spi_req_s;
  target_e           tgt_s;
  logic [ADDR_W-1:0] addr_full_s;
  logic [CNT_W-1:0]  next_bit_s;
  logic [CNT_W-1:0]  next_byte_s;
  logic [7:0]        tx_byte_s;
  logic              eng_start_s;
  logic [7:0]        eng_data_s;
  logic              eng_ready_s;
  logic              eng_done_s;
  logic [7:0]        eng_rx_s;
  logic              eng_sclk_s;
  logic              eng_mosi_s;

  assign req_s       = bus_read | bus_write;
  assign tgt_s       = target_e'(bus_address_in[RAM_BASE_BIT]);
  // Flash is read-only on this bus: flash writes never reach the wire.
  assign spi_req_s   = bus_read | (tgt_s == TGT_RAM);
  assign addr_full_s = ADDR_W'(addr_q);

  // Pick the byte that follows the one currently on the wire.
  always_comb begin
    next_bit_s  = bits_q + CNT_ONE;
    next_byte_s = next_bit_s >> 3'd3;
    tx_byte_s   = is_read_q ? 8'h00 : wdata_q;
    for (int i = 0; i < ADDR_BYTES; i++) begin
      tx_byte_s = (next_byte_s == CNT_W'(i + 1)) ? addr_full_s[8*(ADDR_BYTES-1-i) +: 8] : tx_byte_s;
    end
  end

  // Transaction FSM; the bit counter spans the whole frame so phases fall out of it.
  always_comb begin
    state_d     = state_q;
    bits_d      = bits_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    is_read_d   = is_read_q;
    rdata_d     = rdata_q;
    flash_ce_d  = flash_ce_q;
    ram_ce_d    = ram_ce_q;
    eng_start_s = 1'b0;
    eng_data_s  = tx_byte_s;
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          addr_d    = bus_address_in[14:0];
          wdata_d   = bus_data_in;
          is_read_d = bus_read;
          bits_d    = {CNT_W{1'b0}};
          if (spi_req_s) begin
            state_d     = ST_CMD;
            eng_start_s = 1'b1;
            eng_data_s  = opcode_for(bus_read);
            flash_ce_d  = (tgt_s == TGT_RAM);
            ram_ce_d    = (tgt_s == TGT_FLASH);
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CMD: begin
        bits_d      = eng_sclk_s ? next_bit_s : bits_q;
        eng_start_s = eng_ready_s && (next_bit_s < BITS_ALL);
        state_d     = (bits_d >= CMD_END) ? ST_ADDR : ST_CMD;
      end
      ST_ADDR: begin
        bits_d      = eng_sclk_s ? next_bit_s : bits_q;
        eng_start_s = eng_ready_s && (next_bit_s < BITS_ALL);
        state_d     = (bits_d >= ADDR_END) ? ST_DATA : ST_ADDR;
      end
      ST_DATA: begin
        bits_d      = eng_sclk_s ? next_bit_s : bits_q;
        eng_start_s = eng_ready_s && (next_bit_s < BITS_ALL);
        if (eng_done_s && (bits_q == BITS_ALL)) begin
          state_d    = ST_DONE;
          flash_ce_d = 1'b1;
          ram_ce_d   = 1'b1;
          rdata_d    = is_read_q ? eng_rx_s : rdata_q;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        flash_ce_d = 1'b1;
        ram_ce_d   = 1'b1;
      end
    endcase
  end

  // Controller state registers; reset aborts any transfer and raises both CEs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bits_q     <= {CNT_W{1'b0}};
      addr_q     <= 15'h0000;
      wdata_q    <= 8'h00;
      rdata_q    <= 8'h00;
      is_read_q  <= 1'b0;
      flash_ce_q <= 1'b1;
      ram_ce_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      bits_q     <= bits_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      is_read_q  <= is_read_d;
      flash_ce_q <= flash_ce_d;
      ram_ce_q   <= ram_ce_d;
    end
  end

  spi_shift_engine u_engine (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (eng_start_s),
    .data_i  (eng_data_s),
    .miso_i  (spi_miso),
    .ready_o (eng_ready_s),
    .done_o  (eng_done_s),
    .rx_o    (eng_rx_s),
    .sclk_o  (eng_sclk_s),
    .mosi_o  (eng_mosi_s)
  );

  assign bus_wait     = (state_q == ST_IDLE) ? req_s : (state_q != ST_DONE);
  assign bus_data_out = rdata_q;
  assign flash_ce_n   = flash_ce_q;
  assign ram_ce_n     = ram_ce_q;
  assign spi_clk      = eng_sclk_s;
  assign spi_mosi     = eng_mosi_s;

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Bench for spi_mem_ctrl: SPI flash/RAM slave model on the pins, directed
// vector table, randomized accesses against a memory reference model.
module tb_spi_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bus_address_in = 16'h0000;
  logic [7:0]  bus_data_in = 8'h00;
  logic        bus_read = 1'b0;
  logic        bus_write = 1'b0;
  logic [7:0]  bus_data_out;
  logic        bus_wait;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;
  logic        flash_ce_n;
  logic        ram_ce_n;

  localparam int SPI_WAIT = 2 * (8 + 8 * 3 + 8) + 2;

  spi_mem_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus_address_in (bus_address_in),
    .bus_data_in    (bus_data_in),
    .bus_read       (bus_read),
    .bus_write      (bus_write),
    .bus_data_out   (bus_data_out),
    .bus_wait       (bus_wait),
    .spi_clk        (spi_clk),
    .spi_mosi       (spi_mosi),
    .spi_miso       (spi_miso),
    .flash_ce_n     (flash_ce_n),
    .ram_ce_n       (ram_ce_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Initial memory contents shared by the slave devices and the reference model.
  function automatic logic [7:0] dflt(input logic r, input logic [14:0] a);
    if (!r && a == 15'h0123) return 8'hA5;
    return a[7:0] ^ {1'b0, a[14:8]} ^ (r ? 8'hC3 : 8'h3C);
  endfunction

  // ---------------- SPI slave (flash + RAM) ----------------
  logic [7:0] s_ram [int];
  logic [7:0] s_flash [int];
  logic [7:0] cur_bytes [$];
  logic [7:0] last_bytes [$];
  logic [7:0] sh = 8'h00;
  int   nbit = 0;
  logic prev_sclk = 1'b0;
  logic prev_act = 1'b0;
  logic cur_ram = 1'b0;
  logic last_ram = 1'b0;
  int   txn_count = 0;
  int   rise_count = 0;
  int   hi_cnt = 100;
  int   since_ce = 0;

  function automatic logic [7:0] slave_read(input logic r, input int a);
    if (r) return s_ram.exists(a) ? s_ram[a] : dflt(1'b1, 15'(a));
    return s_flash.exists(a) ? s_flash[a] : dflt(1'b0, 15'(a));
  endfunction

  always @(negedge clk) begin : slave
    logic act;
    int nb;
    int a;
    logic [7:0] b;
    act = !flash_ce_n || !ram_ce_n;
    check("one_ce_max", 32'(flash_ce_n | ram_ce_n), 32'd1);
    check("sclk_without_ce", 32'(spi_clk && !act), 32'd0);
    if (act) begin
      if (!prev_act) begin
        check("ce_high_gap_ge2", 32'(hi_cnt >= 2), 32'd1);
        cur_bytes.delete();
        nbit     = 0;
        sh       = 8'h00;
        cur_ram  = !ram_ce_n;
        since_ce = 0;
      end
      if (spi_clk && !prev_sclk) begin
        rise_count++;
        if (nbit == 0 && cur_bytes.size() == 0) check("ce_lead_cycles", 32'(since_ce), 32'd1);
        sh = {sh[6:0], spi_mosi};
        nbit++;
        if (nbit == 8) begin
          cur_bytes.push_back(sh);
          nbit = 0;
        end
      end
      nb = 8 * cur_bytes.size() + nbit;
      if (!spi_clk && nb >= 32 && nb < 40 && cur_bytes[0] == 8'h03) begin
        a = {8'h00, cur_bytes[1], cur_bytes[2], cur_bytes[3]};
        b = slave_read(cur_ram, a);
        spi_miso = b[7 - (nb - 32)];
      end
      since_ce++;
      hi_cnt = 0;
    end else begin
      if (prev_act) begin
        txn_count++;
        last_bytes = cur_bytes;
        last_ram   = cur_ram;
        if (cur_bytes.size() == 5 && nbit == 0 && cur_bytes[0] == 8'h02) begin
          a = {8'h00, cur_bytes[1], cur_bytes[2], cur_bytes[3]};
          if (cur_ram) s_ram[a] = cur_bytes[4];
          else s_flash[a] = cur_bytes[4];
        end
      end
      hi_cnt++;
    end
    prev_act  = act;
    prev_sclk = spi_clk;
  end

  // ---------------- reference model ----------------
  logic [7:0] m_ram [int];

  function automatic logic [7:0] model_read(input logic [15:0] ad);
    int k;
    k = int'(ad[14:0]);
    if (ad[15]) return m_ram.exists(k) ? m_ram[k] : dflt(1'b1, ad[14:0]);
    return dflt(1'b0, ad[14:0]);
  endfunction

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          exp_wait;
    logic [7:0]  exp_data;
  } vec_t;

  task automatic model_commit(input vec_t v);
    if (!v.rd && v.wr && v.addr[15]) m_ram[int'(v.addr[14:0])] = v.wdata;
  endtask

  // Caller enters just after a posedge in IDLE; returns just after the posedge back into IDLE.
  task automatic run_txn(input vec_t v);
    int cnt;
    int seen0;
    int rises0;
    logic [7:0] eb [5];
    seen0  = txn_count;
    rises0 = rise_count;
    bus_read       = v.rd;
    bus_write      = v.wr;
    bus_address_in = v.addr;
    bus_data_in    = v.wdata;
    cnt = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus_wait) cnt++;
      else break;
    end
    bus_read  = 1'b0;
    bus_write = 1'b0;
    check("wait_cycles", 32'(cnt), 32'(v.exp_wait));
    if (v.rd) check("read_data", 32'(bus_data_out), 32'(v.exp_data));
    @(posedge clk);
    #1;
    if (v.exp_wait == 1) begin
      check("no_spi_txn", 32'(txn_count - seen0), 32'd0);
      check("no_sclk_rise", 32'(rise_count - rises0), 32'd0);
    end else begin
      eb[0] = v.rd ? 8'h03 : 8'h02;
      eb[1] = 8'h00;
      eb[2] = {1'b0, v.addr[14:8]};
      eb[3] = v.addr[7:0];
      eb[4] = v.wdata;
      check("spi_txn", 32'(txn_count - seen0), 32'd1);
      check("ce_target_ram", 32'(last_ram), 32'(v.addr[15]));
      check("mosi_nbytes", 32'(last_bytes.size()), 32'd5);
      for (int i = 0; i < (v.rd ? 4 : 5); i++) begin
        if (i < last_bytes.size()) check("mosi_byte", 32'(last_bytes[i]), 32'(eb[i]));
      end
    end
  endtask

  vec_t tbl [8];

  initial begin : main
    vec_t v;
    logic [15:0] ad;
    tbl[0] = '{1'b1, 1'b0, 16'h0123, 8'h00, SPI_WAIT, 8'hA5};
    tbl[1] = '{1'b0, 1'b1, 16'h8010, 8'h5C, SPI_WAIT, 8'h00};
    tbl[2] = '{1'b1, 1'b0, 16'h8010, 8'h00, SPI_WAIT, 8'h5C};
    tbl[3] = '{1'b0, 1'b1, 16'h0042, 8'h11, 1,        8'h00};
    tbl[4] = '{1'b1, 1'b0, 16'h8000, 8'h00, SPI_WAIT, 8'hC3};
    tbl[5] = '{1'b1, 1'b0, 16'hFFFF, 8'h00, SPI_WAIT, 8'h43};
    tbl[6] = '{1'b1, 1'b1, 16'h8001, 8'h99, SPI_WAIT, 8'hC2};
    tbl[7] = '{1'b1, 1'b0, 16'h8001, 8'h00, SPI_WAIT, 8'hC2};

    // Reset values, and bus_wait following the request while in reset.
    #12;
    check("rst_flash_ce_n", 32'(flash_ce_n), 32'd1);
    check("rst_ram_ce_n", 32'(ram_ce_n), 32'd1);
    check("rst_spi_clk", 32'(spi_clk), 32'd0);
    check("rst_spi_mosi", 32'(spi_mosi), 32'd0);
    check("rst_bus_data_out", 32'(bus_data_out), 32'd0);
    check("rst_bus_wait_idle", 32'(bus_wait), 32'd0);
    bus_read = 1'b1;
    #1;
    check("rst_bus_wait_req", 32'(bus_wait), 32'd1);
    bus_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i]);
      model_commit(tbl[i]);
    end

    for (int i = 0; i < 24; i++) begin
      ad = 16'($urandom);
      if ($urandom_range(0, 1) == 0) ad[14:0] = 15'($urandom_range(0, 7));
      v.rd       = 1'($urandom_range(0, 1));
      v.wr       = !v.rd || ($urandom_range(0, 3) == 0);
      v.addr     = ad;
      v.wdata    = 8'($urandom);
      v.exp_wait = (!v.rd && !ad[15]) ? 1 : SPI_WAIT;
      v.exp_data = v.rd ? model_read(ad) : 8'h00;
      run_txn(v);
      model_commit(v);
    end

    // Reset in the middle of a RAM write's address phase.
    v = '{1'b1, 1'b0, 16'h0123, 8'h00, SPI_WAIT, 8'hA5};
    run_txn(v);
    bus_write      = 1'b1;
    bus_address_in = 16'h8020;
    bus_data_in    = 8'h77;
    for (int c = 0; c < 30; c++) @(negedge clk);
    check("abort_inflight_ram_ce_n", 32'(ram_ce_n), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("abort_ram_ce_n", 32'(ram_ce_n), 32'd1);
    check("abort_flash_ce_n", 32'(flash_ce_n), 32'd1);
    check("abort_spi_clk", 32'(spi_clk), 32'd0);
    check("abort_bus_data_out", 32'(bus_data_out), 32'd0);
    check("abort_bus_wait_req", 32'(bus_wait), 32'd1);
    bus_write = 1'b0;
    #1;
    check("abort_bus_wait_noreq", 32'(bus_wait), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    v = '{1'b1, 1'b0, 16'h8020, 8'h00, SPI_WAIT, 8'h00};
    v.exp_data = model_read(16'h8020);
    run_txn(v);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_mem_ctrl.md
SPI_MEM_CTRL -- requirements
Module: spi_mem_ctrl

Interface
REQ-001 SHALL take parameter ADDR_BYTES, default 3: number of SPI address bytes sent after the opcode.
REQ-002 SHALL take parameter RAM_BASE_BIT, default 15: bus address bit that selects RAM (1) or flash (0).
REQ-003 SHALL have ports clk, input, 1: the single clock; rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have ports bus_address_in, input, 16: CPU address; bus_data_in, input, 8: CPU write data.
REQ-005 SHALL have ports bus_read, input, 1: read request; bus_write, input, 1: write request.
REQ-006 SHALL have ports bus_data_out, output, 8: read data; bus_wait, output, 1: stall the CPU.
REQ-007 SHALL have ports spi_clk, output, 1; spi_mosi, output, 1; spi_miso, input, 1.
REQ-008 SHALL have ports flash_ce_n, output, 1; ram_ce_n, output, 1: active-low chip enables (top maps these to uo_out[7] and uo_out[4]).

Function
REQ-009 SHALL implement the states IDLE, CMD, ADDR, DATA and DONE.
REQ-010 SHALL use SPI mode 0: spi_clk idles low, one half-period per clk cycle, MOSI changes while spi_clk is low, and MISO is sampled on the clk edge that ends each spi_clk-high phase.
REQ-011 SHALL send bits MSB first.
REQ-012 SHALL send opcode 0x03 for reads and 0x02 for writes.
REQ-013 SHALL send the address as {zero pad, bus_address_in[14:0]} over ADDR_BYTES bytes.
REQ-014 SHALL select flash when bus_address_in[RAM_BASE_BIT]=0 and RAM otherwise; at most one CE SHALL be low at any time.
REQ-015 SHALL capture the request in IDLE, when bus_read or bus_write is high, together with the address, write data and target.
REQ-016 SHALL, when bus_read and bus_write are both high, treat the request as a read.
REQ-017 SHALL drive bus_wait combinationally high in IDLE while a request is present, and in CMD, ADDR and DATA.
REQ-018 SHALL drive bus_wait low in DONE, which lasts exactly one cycle before returning to IDLE.
REQ-019 SHALL NOT accept a request in DONE; the CPU drops or changes its request after seeing bus_wait low.
REQ-020 SHALL, for a read, update bus_data_out with the 8 sampled bits on entry to DONE and hold it until the next completed read.
REQ-021 SHALL, for a write, shift the captured data out during DATA, with MISO ignored.
REQ-022 SHALL complete a write targeting flash in IDLE->DONE (bus_wait high for one cycle) with no CE activity.
REQ-023 SHALL, for an SPI transaction, hold bus_wait high for exactly 2*(8+8*ADDR_BYTES+8)+2 cycles (82 at default), counted from the request cycle.
REQ-024 SHALL drive CE low one cycle before the first spi_clk rise.
REQ-025 SHALL return CE high on entry to DONE.
REQ-026 SHALL, between transactions, keep CE high for at least 2 cycles (DONE + IDLE).
REQ-027 SHALL use a bit counter that spans all (16+8*ADDR_BYTES) bits with no wrap-around inside a transaction.

Reset
REQ-028 SHALL, when rst_n is low, asynchronously force: state=IDLE, flash_ce_n=1, ram_ce_n=1, spi_clk=0, spi_mosi=0, bus_data_out=0x00, counters=0.
REQ-029 SHALL drive bus_wait from the request inputs alone while in reset, since the state is IDLE.
REQ-030 SHALL, on reset during a transaction, abort it immediately, raise CE at once and discard partial data.
REQ-031 SHALL start its first transaction no earlier than the first clk edge after rst_n is released.

Structure
REQ-032 SHALL place the opcode constants, the state encoding and the RAM_BASE_BIT default in a shared package, spi_mem_pkg.
REQ-033 SHALL contain one sub-module, spi_shift_engine: an 8-bit serializer/deserializer with bit counter, spi_clk toggle and a done pulse, reused for every byte.
REQ-034 SHALL contain no other sub-modules and no memories; the target RTL size is 150-300 lines.

Verification
REQ-035 Flash read: bus_read at 0x0123, flash model byte 0x0000123=0xA5 -> flash_ce_n low, MOSI=03 00 01 23, bus_wait high 82 cycles, bus_data_out=0xA5, ram_ce_n stays high.
REQ-036 RAM write then read: write 0x5C to 0x8010, then read 0x8010 -> MOSI 02 00 00 10 5C, then read returns 0x5C via ram_ce_n only.
REQ-037 Flash write at 0x0042: bus_wait high 1 cycle, both CEs stay high, spi_clk stays idle.
REQ-038 Back-to-back reads at 0x8000 and 0xFFFF: CE high for >=2 cycles between them; address bytes 00 00 00 and 00 7F FF.
REQ-039 Reset mid-transaction: rst_n low during the ADDR phase -> CE high and spi_clk=0 in the same cycle, bus_data_out=0x00; the next read completes normally.
REQ-040 Simultaneous bus_read and bus_write at 0x8001 -> opcode 0x03 sent and memory unchanged.
